// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, Q = A / B and R = A % B, one quotient bit per cycle.
// A single (n+1)-bit ripple subtractor is shared across all iterations; its borrow-out is the trial compare.
module seq_restoring_divider #(
  parameter int unsigned n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic [n-1:0] Q,
  output logic [n-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         div0
);

  localparam int unsigned CW = $clog2(n + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(n);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t        state_q;
  logic [n-1:0]  q_q, r_q, bq_q;
  logic [CW-1:0] count_q;
  logic          busy_q, done_q, div0_q;

  logic [n:0]    p;
  logic [n-1:0]  t;
  logic [n:0]    bchain;
  logic          borrow;
  logic [n-1:0]  r_d, q_d;

  // Ripple subtractor P - {0,Bq}; the top stage subtracts zero, so only its borrow is kept.
  always_comb begin
    p         = {r_q, q_q[n-1]};
    t         = '0;
    bchain    = '0;
    for (int unsigned i = 0; i < n; i++) begin
      t[i]        = p[i] ^ bq_q[i] ^ bchain[i];
      bchain[i+1] = (~p[i] & bq_q[i]) | (~(p[i] ^ bq_q[i]) & bchain[i]);
    end
    borrow = ~p[n] & bchain[n];
    r_d    = borrow ? p[n-1:0] : t;
    q_d    = {q_q[n-2:0], ~borrow};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      bq_q    <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (B == '0) begin
              q_q     <= '1;
              r_q     <= A;
              div0_q  <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              bq_q    <= B;
              q_q     <= A;
              r_q     <= '0;
              div0_q  <= 1'b0;
              count_q <= CNT_INIT;
              state_q <= ITER;
            end
          end
        end
        ITER: begin
          r_q     <= r_d;
          q_q     <= q_d;
          count_q <= count_q - CNT_ONE;
          if (count_q == CNT_ONE) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: golden A/B, A%B queued at start, compared on done.
module tb_seq_restoring_divider;
  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [N-1:0] A, B, Q, R;
  logic         busy, done, div0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  seq_restoring_divider #(.n(N)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Q(Q), .R(R), .busy(busy), .done(done), .div0(div0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("Q", Q, mon_e.q);
        check("R", R, mon_e.r);
        check("div0", div0, mon_e.dz);
      end
    end
  end

  // intf>0 pulses start with A=9,B=2 on that busy cycle; done_start pulses start during DONE.
  task automatic op(input logic [N-1:0] a, input logic [N-1:0] b,
                    input bit done_start, input int intf);
    int   cyc;
    exp_t e;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    e.q  = (b == 0) ? '1 : a / b;
    e.r  = (b == 0) ? a : a % b;
    e.dz = (b == 0);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    A = N'($urandom);
    B = N'($urandom);
    check("div0_at_accept", div0, (b == 0));
    cyc = 1;
    while (!done && cyc < 4 * N) begin
      check("busy_iter", busy, 1);
      start = (cyc == intf);
      if (start) begin A = 4'd9; B = 4'd2; end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("latency", cyc, (b == 0) ? 1 : N + 1);
    check("busy_done", busy, 1);
    if (done_start) begin
      start = 1'b1;
      A = N'($urandom);
      B = N'($urandom_range(1, 15));
      @(negedge clk);
      start = 1'b0;
      check("start_in_done_ignored", busy, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_Q", Q, 0);
    check("rst_R", R, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_div0", div0, 0);

    op(4'd13, 4'd4, 1'b0, 0);
    op(4'd7, 4'd0, 1'b0, 0);
    op(4'd7, 4'd1, 1'b0, 0);
    op(4'd15, 4'd1, 1'b0, 0);
    op(4'd15, 4'd15, 1'b0, 0);
    op(4'd5, 4'd9, 1'b0, 0);
    op(4'd0, 4'd3, 1'b0, 0);
    op(4'd14, 4'd3, 1'b0, 2);

    @(negedge clk);
    A = 4'd14; B = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_Q", Q, 0);
    check("abort_R", R, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    op(4'd9, 4'd2, 1'b0, 0);

    for (int i = 0; i < 1000; i++) begin
      op(N'($urandom_range(0, 15)), N'($urandom_range(1, 15)),
         ($urandom_range(0, 3) == 0), 0);
    end

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
